// File: rtl/posx_stream_reader_pkg.sv
// Shared definitions for the per-axis position stream reader.
// Holds the default RAM geometry, position word width, RAM read latency,
// output buffer depth and the controller state encoding.
package posx_stream_reader_pkg;

  localparam int unsigned POSX_DEPTH        = 512;
  localparam int unsigned POSX_ADDR_WIDTH   = 9;
  localparam int unsigned POSX_DATA_WIDTH   = 32;
  localparam int unsigned POSX_READ_LATENCY = 2;
  localparam int unsigned POSX_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/posx_stream_reader_if.sv
// Bundle of the reader's host-control, host-load, RAM and output-stream
// signals.
//   slave  : the reader's view (controls RAM, produces the stream)
//   master : the environment's view (host, RAM, downstream sink)
// Host control : start, start_addr, count -> busy, done
// Host load    : ld_valid, ld_addr, ld_data -> ld_ready
// RAM          : mem_address, mem_data, mem_rden, mem_wren -> mem_q
// Stream       : out_valid, out_data, out_index, out_last -> out_ready
interface posx_stream_reader_if
  import posx_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = POSX_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = POSX_DATA_WIDTH
);

  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport slave (
    input  start, start_addr, count, ld_valid, ld_addr, ld_data, mem_q, out_ready,
    output busy, done, ld_ready, mem_address, mem_data, mem_rden, mem_wren,
           out_valid, out_data, out_index, out_last
  );

  modport master (
    output start, start_addr, count, ld_valid, ld_addr, ld_data, mem_q, out_ready,
    input  busy, done, ld_ready, mem_address, mem_data, mem_rden, mem_wren,
           out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/posx_out_fifo.sv
// Synchronous FIFO with a registered output stage.
//   clk, rst   : clock, asynchronous active-high reset
//   wr_en_i    : push wr_data_i (caller guarantees space)
//   rd_en_i    : consumer accepts the presented word
//   rd_valid_o : rd_data_o holds a valid word
//   count_o    : words held, output register included
// A word pushed into an empty FIFO goes straight to the output register,
// so it is presented the cycle after the push.
module posx_out_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mcount_q, mcount_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             pop, load_out, mem_empty, mem_we, mem_re;

  always_comb begin
    pop         = rd_en_i & out_valid_q;
    load_out    = ~out_valid_q | pop;
    mem_empty   = (mcount_q == '0);
    mem_re      = load_out & ~mem_empty;
    // Bypass storage when the output stage is free and nothing is queued.
    mem_we      = wr_en_i & ~(load_out & mem_empty);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_out) begin
      if (!mem_empty) begin
        out_valid_d = 1'b1;
        out_data_d  = storage_q[rd_ptr_q];
      end else if (wr_en_i) begin
        out_valid_d = 1'b1;
        out_data_d  = wr_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    wr_ptr_d = mem_we ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = mem_re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    mcount_d = mcount_q + CW'(mem_we) - CW'(mem_re);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mcount_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mcount_q    <= mcount_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) storage_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_valid_o = out_valid_q;
  assign rd_data_o  = out_data_q;
  assign count_o    = mcount_q + CW'(out_valid_q);

endmodule

// File: rtl/posx_stream_reader.sv
// Controller in front of one per-axis position RAM (single port, registered
// address and output). Accepts host load writes while idle and, on start,
// streams a contiguous wrapping address range out on a valid/ready port.
// Reads are issued only while (inflight + buffered) < FIFO_DEPTH, so the
// output FIFO cannot overflow under any amount of backpressure.
//   clock, rst : clock, asynchronous active-high reset
//   bus        : slave view of posx_stream_reader_if (host control, host
//                load, RAM port, output stream)
module posx_stream_reader
  import posx_stream_reader_pkg::*;
#(
  parameter int unsigned DEPTH        = POSX_DEPTH,
  parameter int unsigned ADDR_WIDTH   = POSX_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = POSX_DATA_WIDTH,
  parameter int unsigned READ_LATENCY = POSX_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH   = POSX_FIFO_DEPTH
) (
  input  logic clock,
  input  logic rst,
  posx_stream_reader_if.slave bus
);

  localparam int unsigned FW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int unsigned IW = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [IW-1:0]         inflight_q, inflight_d;

  logic                  tag_v_q    [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] tag_idx_q  [READ_LATENCY];
  logic                  tag_last_q [READ_LATENCY];

  logic                  issue, credit_ok, emerge, pop;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_valid;
  logic [FW-1:0]         fifo_rdata;

  logic [ADDR_WIDTH-1:0] mem_address_c;
  logic [DATA_WIDTH-1:0] mem_data_c;
  logic                  mem_rden_c, mem_wren_c;

  assign emerge    = tag_v_q[READ_LATENCY-1];
  assign pop       = fifo_valid & bus.out_ready;
  assign credit_ok = (int'(inflight_q) + int'(fifo_count)) < int'(FIFO_DEPTH);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    issue         = 1'b0;
    mem_rden_c    = 1'b0;
    mem_wren_c    = 1'b0;
    mem_address_c = '0;
    mem_data_c    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.ld_valid) begin
          mem_wren_c    = 1'b1;
          mem_address_c = bus.ld_addr;
          mem_data_c    = bus.ld_data;
        end
        if (bus.start) begin
          if (bus.count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d      = bus.start_addr;
            remaining_d = bus.count;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue         = 1'b1;
          mem_rden_c    = 1'b1;
          mem_address_c = addr_q;
          addr_d        = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
          remaining_d   = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the final beat handshakes so done follows it directly.
        if (inflight_q == '0 &&
            (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    inflight_d = inflight_q + IW'(issue) - IW'(emerge);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
    end
  end

  // Tag pipeline tracks each read alongside the RAM latency.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        tag_v_q[i]    <= 1'b0;
        tag_idx_q[i]  <= '0;
        tag_last_q[i] <= 1'b0;
      end
    end else begin
      tag_v_q[0]    <= issue;
      tag_idx_q[0]  <= addr_q;
      tag_last_q[0] <= (remaining_q == REM_ONE);
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i]    <= tag_v_q[i-1];
        tag_idx_q[i]  <= tag_idx_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
      end
    end
  end

  posx_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk        (clock),
    .rst        (rst),
    .wr_en_i    (emerge),
    .wr_data_i  ({bus.mem_q, tag_idx_q[READ_LATENCY-1], tag_last_q[READ_LATENCY-1]}),
    .rd_en_i    (bus.out_ready),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (fifo_rdata),
    .count_o    (fifo_count)
  );

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.ld_ready    = (state_q == S_IDLE);
  assign bus.mem_address = mem_address_c;
  assign bus.mem_data    = mem_data_c;
  assign bus.mem_rden    = mem_rden_c;
  assign bus.mem_wren    = mem_wren_c;
  assign bus.out_valid   = fifo_valid;
  assign bus.out_data    = fifo_rdata[FW-1 -: DATA_WIDTH];
  assign bus.out_index   = fifo_rdata[ADDR_WIDTH:1];
  assign bus.out_last    = fifo_valid & fifo_rdata[0];

endmodule
